audio_sample_fifo: RTL and testbench

AUDIO_SAMPLE_FIFO -- requirements
Module: audio_sample_fifo

---
 rtl/audio_pkg.sv | 11 +
 rtl/audio_rate_gen.sv | 31 +++
 rtl/audio_sample_fifo.sv | 123 ++++++++++++
 tb/tb_audio_sample_fifo.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio definitions: sample width and playback FSM states.
package audio_pkg;

  localparam int unsigned AUDIO_W = 16;

  typedef enum logic {
    PRIME,
    PLAY
  } state_e;

endpackage

// File: rtl/audio_rate_gen.sv
// Free-running sample-rate tick generator: one-cycle tick every clock_max/sample_rate cycles.
module audio_rate_gen #(
  parameter int unsigned clock_max   = 25_000_000,
  parameter int unsigned sample_rate = 48_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  localparam int unsigned Div  = clock_max / sample_rate;
  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(Div - 1);

  logic [CntW-1:0] r_cnt;
  logic            w_last;

  assign w_last = (r_cnt == CntLast);
  assign o_tick = w_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/audio_sample_fifo.sv
// Sample FIFO between the SPI receiver and the DAC: primes to half full, then plays one
// sample per rate tick, flagging overflow (dropped write) and underrun (empty tick).
module audio_sample_fifo
  import audio_pkg::*;
#(
  parameter int unsigned clock_max   = 25_000_000,
  parameter int unsigned sample_rate = 48_000,
  parameter int unsigned depth       = 16
) (
  input  logic                         clk_25mhz,
  input  logic                         reset,
  input  logic                         data_ready,
  input  logic [AUDIO_W-1:0]           audio_in,
  input  logic                         clear_flags,
  output logic [AUDIO_W-1:0]           audio_out,
  output logic                         sample_valid,
  output logic [$clog2(depth+1)-1:0]   fifo_level,
  output logic                         overflow,
  output logic                         underrun
);

  localparam int unsigned LvlW = $clog2(depth + 1);
  localparam int unsigned PtrW = $clog2(depth);
  localparam logic [LvlW-1:0] LvlFull = LvlW'(depth);
  localparam logic [LvlW-1:0] LvlHalf = LvlW'(depth / 2);

  // Assertion is asynchronous; deassertion is released through two flops.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk_25mhz or negedge reset) begin
    if (!reset) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  logic w_tick;

  audio_rate_gen #(
    .clock_max  (clock_max),
    .sample_rate(sample_rate)
  ) u_rate_gen (
    .i_clk  (clk_25mhz),
    .i_rst_n(w_rst_n),
    .o_tick (w_tick)
  );

  logic [AUDIO_W-1:0] r_mem [depth];
  logic [PtrW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [LvlW-1:0]    r_level;
  state_e             r_state, w_state_d;
  logic [AUDIO_W-1:0] r_audio_out;
  logic               r_valid, r_overflow, r_underrun;

  logic w_full, w_empty, w_read, w_underrun_evt, w_write, w_drop;

  assign w_full         = (r_level == LvlFull);
  assign w_empty        = (r_level == '0);
  assign w_read         = (r_state == PLAY) && w_tick && !w_empty;
  assign w_underrun_evt = (r_state == PLAY) && w_tick && w_empty;
  // A same-cycle read frees a slot, so a write to a full FIFO is still accepted.
  assign w_write        = data_ready && (!w_full || w_read);
  assign w_drop         = data_ready && w_full && !w_read;

  always_ff @(posedge clk_25mhz) begin
    if (w_write) begin
      r_mem[r_wr_ptr] <= audio_in;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      PRIME: if (r_level >= LvlHalf) w_state_d = PLAY;
      PLAY:  if (w_underrun_evt)     w_state_d = PRIME;
      default: w_state_d = PRIME;
    endcase
  end

  always_ff @(posedge clk_25mhz or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state     <= PRIME;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_audio_out <= '0;
      r_valid     <= 1'b0;
      r_overflow  <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_valid <= w_read || w_underrun_evt;
      if (w_write) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_read)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      if (w_write && !w_read) begin
        r_level <= r_level + LvlW'(1);
      end else if (w_read && !w_write) begin
        r_level <= r_level - LvlW'(1);
      end
      if (w_read) begin
        r_audio_out <= r_mem[r_rd_ptr];
      end else if (w_underrun_evt) begin
        r_audio_out <= '0;
      end
      // Set events take priority over a coincident clear.
      if (w_drop)           r_overflow <= 1'b1;
      else if (clear_flags) r_overflow <= 1'b0;
      if (w_underrun_evt)   r_underrun <= 1'b1;
      else if (clear_flags) r_underrun <= 1'b0;
    end
  end

  assign audio_out    = r_audio_out;
  assign sample_valid = r_valid;
  assign fifo_level   = r_level;
  assign overflow     = r_overflow;
  assign underrun     = r_underrun;

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Self-checking bench for audio_sample_fifo: directed and random writes against a queue model.
module tb_audio_sample_fifo;

  localparam int CLK_MAX = 100;
  localparam int SR      = 10;
  localparam int DIV     = CLK_MAX / SR;
  localparam int DEPTH   = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        data_ready = 1'b0;
  logic [15:0] audio_in = '0;
  logic        clear_flags = 1'b0;
  logic [15:0] audio_out;
  logic        sample_valid;
  logic [3:0]  fifo_level;
  logic        overflow;
  logic        underrun;

  audio_sample_fifo #(
    .clock_max  (CLK_MAX),
    .sample_rate(SR),
    .depth      (DEPTH)
  ) dut (
    .clk_25mhz   (clk),
    .reset       (reset),
    .data_ready  (data_ready),
    .audio_in    (audio_in),
    .clear_flags (clear_flags),
    .audio_out   (audio_out),
    .sample_valid(sample_valid),
    .fifo_level  (fifo_level),
    .overflow    (overflow),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  // Reference model: sample queue plus playing/priming flag.
  logic [15:0] m_q[$];
  bit          m_play;
  logic [15:0] m_out;
  bit          m_valid, m_ovf, m_unr;
  int          n;  // rising edges since reset release
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("audio_out", 32'(audio_out), 32'(m_out));
    chk("sample_valid", 32'(sample_valid), 32'(m_valid));
    chk("fifo_level", 32'(fifo_level), 32'(m_q.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underrun", 32'(underrun), 32'(m_unr));
  endtask

  task automatic model_reset();
    m_q.delete();
    m_play  = 0;
    m_out   = '0;
    m_valid = 0;
    m_ovf   = 0;
    m_unr   = 0;
    n       = 0;
  endtask

  // Called at a falling edge; drives inputs, advances one cycle, checks outputs.
  task automatic cycle(input bit dr, input logic [15:0] din, input bit clr);
    bit tick, rd, unr, wr, drop, go_play;
    int lvl;
    data_ready  = dr;
    audio_in    = din;
    clear_flags = clr;
    @(posedge clk);
    if (reset) begin
      n++;
      // Two synchroniser edges keep the block in reset; ticks then recur every DIV edges.
      if (n >= 3) begin
        tick    = ((n - 2) % DIV) == 0;
        lvl     = m_q.size();
        rd      = m_play && tick && lvl > 0;
        unr     = m_play && tick && lvl == 0;
        wr      = dr && (lvl < DEPTH || rd);
        drop    = dr && lvl == DEPTH && !rd;
        go_play = !m_play && lvl >= DEPTH / 2;
        m_valid = rd || unr;
        if (rd) m_out = m_q.pop_front();
        else if (unr) m_out = '0;
        if (wr) m_q.push_back(din);
        if (unr) m_play = 0;
        else if (go_play) m_play = 1;
        m_ovf = drop ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_unr = unr ? 1'b1 : (clr ? 1'b0 : m_unr);
      end
    end
    #1;
    chk_all();
    @(negedge clk);
  endtask

  task automatic async_reset();
    reset = 1'b0;
    #1;
    model_reset();
    chk_all();
    cycle(0, '0, 0);
    cycle(0, '0, 0);
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    #1;
    chk_all();
    cycle(0, '0, 0);
    cycle(0, '0, 0);
    reset = 1'b1;

    // Prime with four samples, play them out, then underrun back to PRIME.
    cycle(0, '0, 0);
    cycle(0, '0, 0);
    for (int i = 1; i <= 4; i++) cycle(1, 16'(i), 0);
    while (n < 60) cycle(0, '0, 0);
    chk("underrun_after_drain", 32'(underrun), 32'd1);
    cycle(0, '0, 1);
    chk("underrun_cleared", 32'(underrun), 32'd0);

    // Back-to-back burst forcing overflow, then clear with no event.
    for (int i = 0; i < 10; i++) cycle(1, 16'($urandom), 0);
    cycle(0, '0, 1);
    for (int i = 0; i < 30; i++) cycle(0, '0, 0);

    // Reset in the middle of playback with data buffered.
    for (int i = 0; i < 5; i++) cycle(1, 16'($urandom), 0);
    async_reset();
    for (int i = 0; i < 25; i++) cycle(0, '0, 0);
    for (int i = 0; i < 4; i++) cycle(1, 16'($urandom), 0);

    // Random traffic at varying write rates; clears sometimes land on drops.
    for (int ph = 0; ph < 4; ph++) begin
      int pct;
      pct = (ph == 0) ? 15 : (ph == 1) ? 5 : (ph == 2) ? 40 : 10;
      for (int i = 0; i < 200; i++) begin
        cycle(($urandom_range(0, 99) < pct), 16'($urandom), ($urandom_range(0, 19) == 0));
      end
      if (ph == 1) async_reset();
    end

    // Drop coincident with clear: overflow must remain set.
    for (int i = 0; i < 9; i++) cycle(1, 16'($urandom), 0);
    cycle(1, 16'($urandom), 1);
    for (int i = 0; i < 40; i++) cycle(0, '0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
